// File: rtl/and_64.sv
// 64-bit bitwise AND execution unit for the Y86 ALU (andq).
// Operands are captured on a rising edge; the result and condition flags are registered.
module and_64 #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             zf,
    output logic             sf,
    output logic             of
);

    logic [WIDTH-1:0] and_bits;

    logic [WIDTH-1:0] out_d,       out_q;
    logic             out_valid_d, out_valid_q;
    logic             zf_d,        zf_q;
    logic             sf_d,        sf_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_and_cell
        assign and_bits[i] = a[i] & b[i];
    end

    // Idle cycles only drop out_valid; result and flags hold their last value.
    always_comb begin
        out_d       = out_q;
        zf_d        = zf_q;
        sf_d        = sf_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            out_d       = and_bits;
            zf_d        = (and_bits == '0);
            sf_d        = and_bits[WIDTH-1];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            zf_q        <= 1'b1;
            sf_q        <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            zf_q        <= zf_d;
            sf_q        <= sf_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign zf        = zf_q;
    assign sf        = sf_q;
    assign of        = 1'b0;

endmodule

// File: tb/tb_and_64.sv
// Directed and random checks of and_64: reset values, 1-cycle latency, flags, idle hold, reset priority.
module tb_and_64;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] out;
    logic        out_valid;
    logic        zf;
    logic        sf;
    logic        of;

    int unsigned total;
    int unsigned bad;

    and_64 #(.WIDTH(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .out      (out),
        .out_valid(out_valid),
        .zf       (zf),
        .sf       (sf),
        .of       (of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [63:0] exp_out, input logic exp_valid,
                                input logic exp_zf, input logic exp_sf);
        check_eq({tag, ".out"}, out, exp_out);
        check_eq({tag, ".valid"}, {63'd0, out_valid}, {63'd0, exp_valid});
        check_eq({tag, ".zf"}, {63'd0, zf}, {63'd0, exp_zf});
        check_eq({tag, ".sf"}, {63'd0, sf}, {63'd0, exp_sf});
        check_eq({tag, ".of"}, {63'd0, of}, 64'd0);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic [63:0] rexp;
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        tick();
        tick();
        check_result("reset", 64'd0, 1'b0, 1'b1, 1'b0);

        rst      = 1'b0;
        in_valid = 1'b1;
        a        = 64'd5;
        b        = 64'd3;
        tick();
        check_result("5and3", 64'd1, 1'b1, 1'b0, 1'b0);

        // back-to-back stream, one result per cycle
        a = 64'hF5;  b = 64'd211;
        tick();
        check_result("b2b0", 64'hD1, 1'b1, 1'b0, 1'b0);
        a = 64'd456; b = 64'd789;
        tick();
        check_result("b2b1", 64'd256, 1'b1, 1'b0, 1'b0);
        a = 64'd123; b = 64'd456;
        tick();
        check_result("b2b2", 64'd72, 1'b1, 1'b0, 1'b0);

        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h8000_0000_0000_0000;
        tick();
        check_result("sign", 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
        a = 64'hAAAA_AAAA_AAAA_AAAA; b = 64'h5555_5555_5555_5555;
        tick();
        check_result("alt", 64'd0, 1'b1, 1'b1, 1'b0);

        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        check_result("ones", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
        a = 64'd0; b = 64'h1234_5678_9ABC_DEF0;
        tick();
        check_result("azero", 64'd0, 1'b1, 1'b1, 1'b0);
        a = 64'hF000_0000_0000_00FF; b = 64'h9000_0000_0000_0F0F;
        tick();
        check_result("negneg", 64'h9000_0000_0000_000F, 1'b1, 1'b0, 1'b1);

        // idle: valid drops, result and flags hold
        in_valid = 1'b0;
        a = 64'd0; b = 64'd0;
        tick();
        check_result("idle0", 64'h9000_0000_0000_000F, 1'b0, 1'b0, 1'b1);
        tick();
        check_result("idle1", 64'h9000_0000_0000_000F, 1'b0, 1'b0, 1'b1);

        // reset wins over in_valid
        in_valid = 1'b1;
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF;
        rst = 1'b1;
        tick();
        check_result("rstwin", 64'd0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        a = 64'd12; b = 64'd10;
        tick();
        check_result("postrst", 64'd8, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            if ((i % 10) == 3) rb = ~ra;
            rexp = ra & rb;
            a = ra;
            b = rb;
            tick();
            check_result("rand", rexp, 1'b1, (rexp == 64'd0), rexp[63]);
        end

        in_valid = 1'b0;
        tick();
        check_result("endidle", rexp, 1'b0, (rexp == 64'd0), rexp[63]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
